gem_fiber_tx_ctrl: RTL and testbench

GEM_FIBER_TX_CTRL -- requirements
Module: gem_fiber_tx_ctrl

---
 rtl/gem_fiber_tx_ctrl.sv | 137 +++++++++++++
 tb/tb_gem_fiber_tx_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gem_fiber_tx_ctrl.sv
// GTX transmitter bring-up sequencer: PLL reset, GTX reset, phase-alignment wait and
// comma/reset pattern, with lock/done supervision and timeout retry accounting.
module gem_fiber_tx_ctrl #(
  parameter int PLLRST_CYCLES = 16,
  parameter int GTXRST_CYCLES = 16,
  parameter int SYNC_FRAMES   = 64,
  parameter int TIMEOUT       = 50000,
  parameter int SIM_SPEEDUP   = 0
) (
  input  logic       TRG_CLK80,
  input  logic       RST,
  input  logic       TRG_TX_PLL_LOCK,
  input  logic       TRG_TXRESETDONE,
  input  logic       TX_SYNC_DONE,
  input  logic       RESYNC,
  input  logic       CLR_ERR,
  output logic       TRG_TX_PLLRST,
  output logic       TRG_GTXTXRST,
  output logic       TRG_RST,
  output logic       LINK_READY,
  output logic [2:0] STATE,
  output logic [7:0] RETRY_CNT,
  output logic       ERR_TIMEOUT
);

  typedef enum logic [2:0] {
    S_PLLRST    = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_GTXRST    = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_WAIT_SYNC = 3'd4,
    S_SEND_RST  = 3'd5,
    S_READY     = 3'd6
  } state_t;

  localparam int          EFF_TIMEOUT = (SIM_SPEEDUP == 1) ? (TIMEOUT / 64) : TIMEOUT;
  localparam logic [15:0] PLL_LAST    = 16'(PLLRST_CYCLES - 1);
  localparam logic [15:0] GTX_LAST    = 16'(GTXRST_CYCLES - 1);
  localparam logic [15:0] SYNC_LAST   = 16'(SYNC_FRAMES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(EFF_TIMEOUT - 1);

  logic        lock_m, lock_s;
  logic        done_m, done_s;
  state_t      state, state_nxt;
  logic [15:0] timer;
  logic        tmo;

  // Lock and reset-done come from the GTX hard block, not from TRG_CLK80.
  always_ff @(posedge TRG_CLK80) begin
    if (RST) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      lock_m <= TRG_TX_PLL_LOCK;
      lock_s <= lock_m;
      done_m <= TRG_TXRESETDONE;
      done_s <= done_m;
    end
  end

  always_comb begin
    state_nxt = state;
    tmo       = 1'b0;
    case (state)
      S_PLLRST: begin
        if (timer == PLL_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s) state_nxt = S_GTXRST;
        else if (timer == TMO_LAST) begin
          state_nxt = S_PLLRST;
          tmo       = 1'b1;
        end
      end
      S_GTXRST: begin
        if (timer == GTX_LAST) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!lock_s) state_nxt = S_PLLRST;
        else if (done_s) state_nxt = S_WAIT_SYNC;
        else if (timer == TMO_LAST) begin
          state_nxt = S_GTXRST;
          tmo       = 1'b1;
        end
      end
      S_WAIT_SYNC: begin
        if (!lock_s) state_nxt = S_PLLRST;
        else if (!done_s) state_nxt = S_GTXRST;
        else if (TX_SYNC_DONE) state_nxt = S_SEND_RST;
        else if (timer == TMO_LAST) begin
          state_nxt = S_GTXRST;
          tmo       = 1'b1;
        end
      end
      S_SEND_RST: begin
        if (!lock_s) state_nxt = S_PLLRST;
        else if (!done_s) state_nxt = S_GTXRST;
        else if (timer == SYNC_LAST) state_nxt = S_READY;
      end
      S_READY: begin
        if (!lock_s) state_nxt = S_PLLRST;
        else if (!done_s) state_nxt = S_GTXRST;
        else if (RESYNC) state_nxt = S_SEND_RST;
      end
      default: state_nxt = S_PLLRST;
    endcase
  end

  // Outputs are registered from the next state so they line up with STATE,
  // except LINK_READY, which waits one full clock in READY before rising.
  always_ff @(posedge TRG_CLK80) begin
    if (RST) begin
      state         <= S_PLLRST;
      timer         <= 16'd0;
      TRG_TX_PLLRST <= 1'b1;
      TRG_GTXTXRST  <= 1'b1;
      TRG_RST       <= 1'b1;
      LINK_READY    <= 1'b0;
      RETRY_CNT     <= 8'd0;
      ERR_TIMEOUT   <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= (state_nxt != state) ? 16'd0 : timer + 16'd1;
      TRG_TX_PLLRST <= (state_nxt == S_PLLRST);
      TRG_GTXTXRST  <= (state_nxt == S_PLLRST) || (state_nxt == S_GTXRST);
      TRG_RST       <= (state_nxt != S_READY);
      LINK_READY    <= (state == S_READY) && (state_nxt == S_READY);
      if (tmo && (RETRY_CNT != 8'hFF)) RETRY_CNT <= RETRY_CNT + 8'd1;
      ERR_TIMEOUT   <= tmo | (ERR_TIMEOUT & ~CLR_ERR);
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_gem_fiber_tx_ctrl.sv
// Self-checking bench for gem_fiber_tx_ctrl: directed bring-up scenarios plus random
// input traffic, all compared every cycle against a table-driven sequencer model.
module tb_gem_fiber_tx_ctrl;

  localparam int PLL = 16;
  localparam int GTX = 16;
  localparam int SF  = 64;
  localparam int TMO = 6400;
  localparam int EFF = TMO / 64;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       lock = 1'b0, done = 1'b0, sync = 1'b0, resync = 1'b0, clr = 1'b0;
  logic       trg_tx_pllrst, trg_gtxtxrst, trg_rst, link_ready, err_timeout;
  logic [2:0] state;
  logic [7:0] retry_cnt;

  gem_fiber_tx_ctrl #(
    .PLLRST_CYCLES(PLL),
    .GTXRST_CYCLES(GTX),
    .SYNC_FRAMES  (SF),
    .TIMEOUT      (TMO),
    .SIM_SPEEDUP  (1)
  ) dut (
    .TRG_CLK80      (clk),
    .RST            (rst),
    .TRG_TX_PLL_LOCK(lock),
    .TRG_TXRESETDONE(done),
    .TX_SYNC_DONE   (sync),
    .RESYNC         (resync),
    .CLR_ERR        (clr),
    .TRG_TX_PLLRST  (trg_tx_pllrst),
    .TRG_GTXTXRST   (trg_gtxtxrst),
    .TRG_RST        (trg_rst),
    .LINK_READY     (link_ready),
    .STATE          (state),
    .RETRY_CNT      (retry_cnt),
    .ERR_TIMEOUT    (err_timeout)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // behavioural model: phase code, clocks spent in the phase, retry/err, sync pipes
  int m_state = 0, m_age = 0, m_retry = 0, m_err = 0;
  bit lk1 = 0, lk2 = 0, dn1 = 0, dn2 = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int nxt, dwell;
    bit ls, ds, ok, to;
    if (rst) begin
      m_state = 0; m_age = 0; m_retry = 0; m_err = 0;
      lk1 = 0; lk2 = 0; dn1 = 0; dn2 = 0;
    end else begin
      ls = lk2; ds = dn2;
      lk2 = lk1; lk1 = lock;
      dn2 = dn1; dn1 = done;
      nxt = m_state;
      to  = 0;
      if ((m_state inside {3, 4, 5, 6}) && !ls) nxt = 0;
      else if ((m_state inside {4, 5, 6}) && !ds) nxt = 2;
      else begin
        case (m_state)
          0, 2, 5: begin
            dwell = (m_state == 0) ? PLL : (m_state == 2) ? GTX : SF;
            if (m_age + 1 == dwell) nxt = m_state + 1;
          end
          1, 3, 4: begin
            ok = (m_state == 1) ? ls : (m_state == 3) ? ds : sync;
            if (ok) nxt = m_state + 1;
            else if (m_age + 1 == EFF) begin
              to  = 1;
              nxt = (m_state == 1) ? 0 : 2;
            end
          end
          6: if (resync) nxt = 5;
          default: nxt = 0;
        endcase
      end
      m_age   = (nxt == m_state) ? m_age + 1 : 0;
      m_state = nxt;
      if (to && m_retry < 255) m_retry++;
      if (to) m_err = 1;
      else if (clr) m_err = 0;
    end
  endtask

  task automatic compare();
    chk("state",      int'(state),         m_state);
    chk("pllrst",     int'(trg_tx_pllrst), int'(m_state == 0));
    chk("gtxtxrst",   int'(trg_gtxtxrst),  int'(m_state == 0 || m_state == 2));
    chk("trg_rst",    int'(trg_rst),       int'(m_state != 6));
    chk("link_ready", int'(link_ready),    int'(m_state == 6 && m_age >= 1));
    chk("retry_cnt",  int'(retry_cnt),     m_retry);
    chk("err",        int'(err_timeout),   m_err);
  endtask

  // driver: one clock, model update at the edge, compare at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  initial begin
    int gtx_cnt, s5_cnt, first_link, lat, got, rst_cnt, ov;
    int tmo_seen, t_first, t_second, prev_state;
    bit hold;

    repeat (3) cycle();
    chk("rst_state",   int'(state), 0);
    chk("rst_pllrst",  int'(trg_tx_pllrst), 1);
    chk("rst_gtxrst",  int'(trg_gtxtxrst), 1);
    chk("rst_trg_rst", int'(trg_rst), 1);
    chk("rst_link",    int'(link_ready), 0);
    chk("rst_retry",   int'(retry_cnt), 0);

    // nominal bring-up
    lock = 1; done = 1; sync = 1; rst = 0;
    gtx_cnt = 0; s5_cnt = 0; first_link = -1;
    for (int k = 1; k <= 120; k++) begin
      cycle();
      if (trg_gtxtxrst) gtx_cnt++;
      if (state == 3'd5) s5_cnt++;
      if (link_ready && first_link < 0) first_link = k;
    end
    chk("nom_gtxrst_clks", gtx_cnt, 31);
    chk("nom_sendrst_clks", s5_cnt, 64);
    chk("nom_link_cycle", first_link, 100);
    chk("nom_retry", int'(retry_cnt), 0);

    // lock loss in READY
    lock = 0; lat = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (state == 3'd0) begin
        lat = k;
        break;
      end
    end
    chk("lockloss_latency", lat, 3);
    chk("lockloss_link", int'(link_ready), 0);
    chk("lockloss_trg_rst", int'(trg_rst), 1);
    lock = 1; got = -1;
    for (int k = 1; k <= 300; k++) begin
      cycle();
      if (link_ready) begin
        got = k;
        break;
      end
    end
    chk("rebringup_cycles", got, 100);

    // one-cycle resync in READY
    repeat (2) cycle();
    resync = 1; rst_cnt = 0; ov = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      resync = 0;
      if (trg_rst) rst_cnt++;
      if (trg_rst && link_ready) ov++;
    end
    chk("resync_len", rst_cnt, 64);
    chk("resync_overlap", ov, 0);
    chk("resync_back_ready", int'(state), 6);
    chk("resync_link", int'(link_ready), 1);

    // reset while in READY
    rst = 1;
    cycle();
    chk("midrst_state", int'(state), 0);
    chk("midrst_link", int'(link_ready), 0);
    rst = 0;

    // repeated lock timeouts, saturation, clear-vs-set
    lock = 0;
    tmo_seen = 0; t_first = -1; t_second = -1; prev_state = int'(state);
    for (int k = 0; k < 300 * (PLL + EFF) && tmo_seen < 260; k++) begin
      hold = (m_retry == 200 && m_state == 1 && m_age == EFF - 1);
      clr = hold;
      cycle();
      clr = 0;
      if (hold) begin
        chk("err_set_wins", int'(err_timeout), 1);
        chk("retry_at_201", int'(retry_cnt), 201);
      end
      if (prev_state == 1 && state == 3'd0) begin
        tmo_seen++;
        if (t_first < 0) t_first = cyc;
        else if (t_second < 0) t_second = cyc;
      end
      prev_state = int'(state);
    end
    chk("timeouts_seen", tmo_seen, 260);
    chk("retry_period", t_second - t_first, PLL + EFF);
    chk("retry_saturated", int'(retry_cnt), 255);
    chk("tmo_link_low", int'(link_ready), 0);
    chk("tmo_err_set", int'(err_timeout), 1);
    clr = 1;
    cycle();
    clr = 0;
    chk("err_cleared", int'(err_timeout), 0);
    chk("retry_held", int'(retry_cnt), 255);

    // random traffic
    lock = 1; done = 1; sync = 0;
    for (int k = 0; k < 20000; k++) begin
      if (lock ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 29) == 0)) lock = ~lock;
      if (done ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 29) == 0)) done = ~done;
      if ($urandom_range(0, 49) == 0) sync = ~sync;
      resync = ($urandom_range(0, 99) == 0);
      clr    = ($urandom_range(0, 149) == 0);
      rst    = ($urandom_range(0, 3999) == 0);
      cycle();
    end
    rst = 0; resync = 0; clr = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
